// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared constants for the GCD job sequencer
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  // The engine latches its first data_in word as A and the second as B.
  localparam bit OPERAND_A_FIRST = 1'b1;

endpackage

// File: rtl/gcd_watchdog.sv
// rtl/gcd_watchdog.sv - saturating wait-cycle counter with expiry flag
module gcd_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count_q;

  // Saturates at LIMIT so a stuck enable can never wrap back to a small count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && (count_q < LIMIT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = enable && (count_q >= LIMIT);

endmodule

// File: rtl/gcd_job_sequencer.sv
// rtl/gcd_job_sequencer.sv - valid/ready front end serialising operands onto the GCD engine
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic [WIDTH-1:0] gcd_result,
  input  logic             gcd_done,
  output logic             busy
);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, gcd_q;
  logic             err_q;
  logic             bypass;
  logic             wd_expired;

  // Zero operands would never terminate in the subtractive engine; equal ones are trivial.
  assign bypass = (in_a == '0) || (in_b == '0) || (in_a == in_b);

  gcd_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == S_LOAD_B),
    .enable  (state_q == S_WAIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = bypass ? S_OUT : S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_WAIT;
      S_WAIT:   if (gcd_done || wd_expired) state_d = S_OUT;
      S_OUT:    if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      gcd_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
            if (bypass) begin
              gcd_q <= (in_a == '0) ? in_b : in_a;
              err_q <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          // done takes priority over a simultaneous watchdog expiry
          if (gcd_done) begin
            gcd_q <= gcd_result;
            err_q <= 1'b0;
          end else if (wd_expired) begin
            gcd_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_OUT);
    gcd_start = 1'b0;
    gcd_data  = '0;
    case (state_q)
      S_LOAD_A: begin
        gcd_start = 1'b1;
        gcd_data  = OPERAND_A_FIRST ? a_q : b_q;
      end
      S_LOAD_B, S_WAIT: begin
        gcd_start = 1'b1;
        gcd_data  = OPERAND_A_FIRST ? b_q : a_q;
      end
      default: ;
    endcase
  end

  assign out_gcd = gcd_q;
  assign out_err = err_q;

endmodule
